parking_exit_tracker: RTL and testbench

Exit-gate counterpart to the parking-lot entry counter. Decodes car departures from two beam sensors at the exit lane with a direction-checking FSM, and counts total exits. Maintains lot occupancy from the entry side's accepted-car pulse and this block's exit decisions, and drives the full flag back to the entry logic. Also drives the empty flag and error pulses.

---
 rtl/parking_exit_tracker_if.sv | 28 ++
 rtl/parking_exit_tracker.sv | 136 +++++++++++++
 tb/tb_parking_exit_tracker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/parking_exit_tracker_if.sv
// Exit-lane bus for parking_exit_tracker.
// The master drives the beam sensors and the entry gate's accepted-car pulse.
// The slave (the tracker) returns the counters, the flags and the event pulses.
interface parking_exit_tracker_if #(
  parameter int CNT_W = 16,
  parameter int OCC_W = 5
) ();
  logic             sensor_a;
  logic             sensor_b;
  logic             car_entered;
  logic             exit_pulse;
  logic [CNT_W-1:0] car_out;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             wrong_way;
  logic             underflow;

  modport master (
    output sensor_a, sensor_b, car_entered,
    input  exit_pulse, car_out, occupancy, full, empty, wrong_way, underflow
  );

  modport slave (
    input  sensor_a, sensor_b, car_entered,
    output exit_pulse, car_out, occupancy, full, empty, wrong_way, underflow
  );
endinterface

// File: rtl/parking_exit_tracker.sv
// Exit-gate tracker for the parking lot.
// A direction-checking FSM decodes departures from the two exit beams
// (inner beam a, outer beam b). The block counts total exits and keeps lot
// occupancy from entry pulses and exit decisions. It returns full/empty to
// the entry logic and raises wrong-way and underflow event pulses.
module parking_exit_tracker #(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = 16,
  parameter int OCC_W    = 5
) (
  input logic                  clk,
  input logic                  reset,
  parking_exit_tracker_if.slave bus
);

  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE,
    A_ONLY,
    BOTH,
    B_ONLY,
    WAIT_CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ab;
  logic             exit_dec;
  logic             wrong_dec;
  logic             occ_zero;
  logic             occ_inc;
  logic             occ_dec;

  logic [CNT_W-1:0] car_out_q;
  logic [OCC_W-1:0] occupancy_q;
  logic             exit_pulse_q;
  logic             wrong_way_q;
  logic             underflow_q;

  assign ab = {bus.sensor_a, bus.sensor_b};

  // Next-state decode of the beam pattern; flags the exit and wrong-way events.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    exit_dec  = 1'b0;
    wrong_dec = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (ab)
          2'b10: state_d = A_ONLY;
          2'b01: begin
            state_d   = WAIT_CLEAR;
            wrong_dec = 1'b1;
          end
          2'b11: state_d = WAIT_CLEAR;
          default: state_d = IDLE;
        endcase
      end
      A_ONLY: begin
        unique case (ab)
          2'b11: state_d = BOTH;
          2'b00: state_d = IDLE;        // car backed off before reaching beam b
          2'b01: state_d = WAIT_CLEAR;
          default: state_d = A_ONLY;
        endcase
      end
      BOTH: begin
        unique case (ab)
          2'b01: state_d = B_ONLY;
          2'b10: state_d = A_ONLY;      // reversal back into the lot
          2'b00: state_d = WAIT_CLEAR;  // both beams dropped together: not trusted
          default: state_d = BOTH;
        endcase
      end
      B_ONLY: begin
        unique case (ab)
          2'b00: begin
            state_d  = IDLE;
            exit_dec = 1'b1;
          end
          2'b11: state_d = BOTH;        // reversal
          2'b10: state_d = WAIT_CLEAR;
          default: state_d = B_ONLY;
        endcase
      end
      WAIT_CLEAR: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // An exit only counts against a car already in the lot (pre-edge occupancy).
  // An entry on the same edge as a counted exit cancels it out, even at capacity.
  assign occ_zero = (occupancy_q == '0);
  assign occ_dec  = exit_dec && !occ_zero;
  assign occ_inc  = bus.car_entered && ((occupancy_q < CAP_V) || occ_dec);

  // Counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_out_q    <= '0;
      occupancy_q  <= '0;
      exit_pulse_q <= 1'b0;
      wrong_way_q  <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      exit_pulse_q <= occ_dec;
      wrong_way_q  <= wrong_dec;
      underflow_q  <= exit_dec && occ_zero;
      if (occ_dec) car_out_q <= car_out_q + 1'b1;  // wraps modulo 2**CNT_W
      unique case ({occ_inc, occ_dec})
        2'b10:   occupancy_q <= occupancy_q + 1'b1;
        2'b01:   occupancy_q <= occupancy_q - 1'b1;
        default: occupancy_q <= occupancy_q;
      endcase
    end
  end

  assign bus.car_out    = car_out_q;
  assign bus.occupancy  = occupancy_q;
  assign bus.exit_pulse = exit_pulse_q;
  assign bus.wrong_way  = wrong_way_q;
  assign bus.underflow  = underflow_q;
  assign bus.full       = (occupancy_q == CAP_V);
  assign bus.empty      = occ_zero;

endmodule

// File: tb/tb_parking_exit_tracker.sv
// Self-checking bench for parking_exit_tracker.
// Each driven cycle pushes the reference model's expected outputs onto a
// scoreboard queue. The entry is popped and compared just after the clock edge.
module tb_parking_exit_tracker;

  localparam int CAPACITY = 16;
  localparam int CNT_W    = 16;
  localparam int OCC_W    = 5;

  logic clk;
  logic reset;

  parking_exit_tracker_if #(.CNT_W(CNT_W), .OCC_W(OCC_W)) bus ();

  parking_exit_tracker #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W),
    .OCC_W   (OCC_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             exit_pulse;
    logic [CNT_W-1:0] car_out;
    logic [OCC_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             wrong_way;
    logic             underflow;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 IDLE, 1 A_ONLY, 2 BOTH, 3 B_ONLY, 4 WAIT_CLEAR.
  // The table is indexed [state][ab] with ab = {sensor_a, sensor_b}.
  int next_tab [5][4] = '{
    '{0, 4, 1, 4},
    '{0, 4, 1, 2},
    '{4, 3, 1, 2},
    '{0, 3, 4, 2},
    '{0, 4, 4, 4}
  };
  int               m_state = 0;
  int               m_occ   = 0;
  logic [CNT_W-1:0] m_car   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, predict its result, push it, then pop and compare after the edge.
  task automatic step(input logic [1:0] ab, input logic ent, input logic rst);
    exp_t e;
    logic is_exit;
    bus.sensor_a    = ab[1];
    bus.sensor_b    = ab[0];
    bus.car_entered = ent;
    reset           = rst;
    e = '0;
    if (rst) begin
      m_state = 0;
      m_occ   = 0;
      m_car   = '0;
    end else begin
      is_exit     = (m_state == 3) && (ab == 2'b00);
      e.wrong_way = (m_state == 0) && (ab == 2'b01);
      e.exit_pulse = is_exit && (m_occ > 0);
      e.underflow  = is_exit && (m_occ == 0);
      if (e.exit_pulse) begin
        m_car = m_car + 1'b1;
        if (!ent) m_occ = m_occ - 1;
      end else if (ent && m_occ < CAPACITY) begin
        m_occ = m_occ + 1;
      end
      m_state = next_tab[m_state][ab];
    end
    e.car_out   = m_car;
    e.occupancy = OCC_W'(m_occ);
    e.full      = (m_occ == CAPACITY);
    e.empty     = (m_occ == 0);
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underrun", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("exit_pulse", 32'(bus.exit_pulse), 32'(e.exit_pulse));
      check("car_out",    32'(bus.car_out),    32'(e.car_out));
      check("occupancy",  32'(bus.occupancy),  32'(e.occupancy));
      check("full",       32'(bus.full),       32'(e.full));
      check("empty",      32'(bus.empty),      32'(e.empty));
      check("wrong_way",  32'(bus.wrong_way),  32'(e.wrong_way));
      check("underflow",  32'(bus.underflow),  32'(e.underflow));
    end
  endtask

  // Legal exit 10,11,01,00 with the entry/reset inputs given for the final 00.
  task automatic exit_seq(input logic ent_last, input logic rst_last);
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, ent_last, rst_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sensor_a    = 1'b0;
    bus.sensor_b    = 1'b0;
    bus.car_entered = 1'b0;
    reset           = 1'b1;
    @(negedge clk);

    // Reset held two cycles while sensors and entry are active.
    step(2'b10, 1'b1, 1'b1);
    step(2'b01, 1'b1, 1'b1);
    check("rst_car_out", 32'(bus.car_out), 32'd0);
    check("rst_occ",     32'(bus.occupancy), 32'd0);
    check("rst_empty",   32'(bus.empty), 32'd1);
    check("rst_full",    32'(bus.full), 32'd0);
    check("rst_pulses",  32'({bus.exit_pulse, bus.wrong_way, bus.underflow}), 32'd0);

    // Three entries, then an exit with repeated values.
    repeat (3) step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check("t2_exit_pulse", 32'(bus.exit_pulse), 32'd1);
    check("t2_car_out",    32'(bus.car_out), 32'd1);
    check("t2_occ",        32'(bus.occupancy), 32'd2);
    step(2'b00, 1'b0, 1'b0);
    check("t2_pulse_one_cycle", 32'(bus.exit_pulse), 32'd0);

    // Reversals still count exactly one exit.
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check("t3_car_out", 32'(bus.car_out), 32'd2);
    check("t3_occ",     32'(bus.occupancy), 32'd1);
    // Car backs off: no count.
    step(2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check("t3_backoff", 32'(bus.car_out), 32'd2);

    // Wrong-way entry into the exit lane.
    step(2'b01, 1'b0, 1'b0);
    check("t4_wrong_way", 32'(bus.wrong_way), 32'd1);
    step(2'b11, 1'b0, 1'b0);
    check("t4_ww_one_cycle", 32'(bus.wrong_way), 32'd0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check("t4_no_count", 32'(bus.car_out), 32'd2);
    exit_seq(1'b0, 1'b0);
    check("t4_next_exit", 32'(bus.car_out), 32'd3);
    check("t4_occ",       32'(bus.occupancy), 32'd0);

    // Exit from an empty lot, then fill to capacity and beyond.
    exit_seq(1'b0, 1'b0);
    check("t5_underflow", 32'(bus.underflow), 32'd1);
    check("t5_car_out",   32'(bus.car_out), 32'd3);
    check("t5_no_exit",   32'(bus.exit_pulse), 32'd0);
    repeat (CAPACITY) step(2'b00, 1'b1, 1'b0);
    check("t5_full", 32'(bus.full), 32'd1);
    step(2'b00, 1'b1, 1'b0);
    check("t5_saturate", 32'(bus.occupancy), 32'd16);

    // Entry on the same edge as a counted exit, then with reset on that edge.
    step(2'b00, 1'b0, 1'b1);
    repeat (5) step(2'b00, 1'b1, 1'b0);
    exit_seq(1'b1, 1'b0);
    check("t6_occ",        32'(bus.occupancy), 32'd5);
    check("t6_car_out",    32'(bus.car_out), 32'd1);
    check("t6_exit_pulse", 32'(bus.exit_pulse), 32'd1);
    exit_seq(1'b1, 1'b1);
    check("t6_rst_car_out", 32'(bus.car_out), 32'd0);
    check("t6_rst_occ",     32'(bus.occupancy), 32'd0);
    check("t6_rst_pulse",   32'(bus.exit_pulse), 32'd0);
    check("t6_rst_empty",   32'(bus.empty), 32'd1);

    // Simultaneous entry and an exit decoded from an empty lot.
    exit_seq(1'b1, 1'b0);
    check("t7_underflow", 32'(bus.underflow), 32'd1);
    check("t7_occ",       32'(bus.occupancy), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 150) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
